// File: rtl/me_sched_pkg.sv
// me_sched_pkg: shared state encoding and default geometry for the ME block scheduler.
package me_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRIME    = 3'd1,
        WAIT_REF = 3'd2,
        RUN      = 3'd3,
        FINISH   = 3'd4
    } sched_state_e;

    localparam int DEF_BLOCKS_PER_LINE  = 482;
    localparam int DEF_LINES_PER_FRAME  = 270;
    localparam int DEF_CYCLES_PER_BLOCK = 23;
    localparam int DEF_CUR_LOAD_CYCLES  = 16;
    localparam int DEF_PRIME_BLOCKS     = 2;
    localparam int DEF_BX_W             = 9;
    localparam int DEF_BY_W             = 9;

    function automatic int total_blocks(input int blocks_per_line, input int lines_per_frame);
        return blocks_per_line * lines_per_frame;
    endfunction

endpackage

// File: rtl/me_phase_timer.sv
// me_phase_timer: loadable down-counter; tc flags the terminal (zero) count.
module me_phase_timer #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count_next,
    output logic         tc
);
    logic [W-1:0] count;

    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_val;
        end else if (count != '0) begin
            count_next = count - W'(1);
        end
    end

    assign tc = (count == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/me_block_scheduler.sv
// me_block_scheduler: control sequencer for the ME datapath (prime, reference line switch, block timing).
// Build option: define ME_SCHED_PERF_EN to add the perf_cycles/perf_stalls counters.
module me_block_scheduler
    import me_sched_pkg::*;
#(
    parameter int BLOCKS_PER_LINE  = DEF_BLOCKS_PER_LINE,
    parameter int LINES_PER_FRAME  = DEF_LINES_PER_FRAME,
    parameter int CYCLES_PER_BLOCK = DEF_CYCLES_PER_BLOCK,
    parameter int CUR_LOAD_CYCLES  = DEF_CUR_LOAD_CYCLES,
    parameter int PRIME_BLOCKS     = DEF_PRIME_BLOCKS,
    parameter int BX_W             = DEF_BX_W,
    parameter int BY_W             = DEF_BY_W
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start,
    input  logic            abort,
    input  logic            sram_ready,
    output logic            ref_next_line,
    output logic            cur_read_en,
    output logic            cur_next_block,
    output logic            ad_valid,
    output logic            block_done,
    output logic [BX_W-1:0] block_x,
    output logic [BY_W-1:0] block_y,
    output logic            busy,
    output logic            frame_done,
    output logic [31:0]     perf_cycles,
    output logic [31:0]     perf_stalls
);
    // state    | meaning
    // IDLE     | waiting for start
    // PRIME    | cold-boot load of the first current blocks
    // WAIT_REF | next reference line requested, waiting for sram_ready
    // RUN      | AD array processing one block per CYCLES_PER_BLOCK cycles
    // FINISH   | one-cycle frame_done, then back to IDLE

    localparam int PRIME_LEN = PRIME_BLOCKS * CUR_LOAD_CYCLES;
    localparam int TOTAL     = total_blocks(BLOCKS_PER_LINE, LINES_PER_FRAME);
    localparam int TW_RUN    = $clog2(CYCLES_PER_BLOCK);
    localparam int TW_PRIME  = $clog2(PRIME_LEN);
    localparam int TW        = (TW_RUN > TW_PRIME) ? TW_RUN : TW_PRIME;

    localparam logic [TW-1:0]   PRIME_LAST = TW'(PRIME_LEN - 1);
    localparam logic [TW-1:0]   RUN_LAST   = TW'(CYCLES_PER_BLOCK - 1);
    localparam logic [TW-1:0]   CUR_OFF    = TW'(CYCLES_PER_BLOCK - CUR_LOAD_CYCLES - 1);
    localparam logic [BX_W-1:0] BX_LAST    = BX_W'(BLOCKS_PER_LINE - 1);
    localparam logic [BY_W-1:0] BY_LAST    = BY_W'(LINES_PER_FRAME - 1);
    localparam logic [31:0]     PF_INIT    = (TOTAL > PRIME_BLOCKS) ? 32'(TOTAL - PRIME_BLOCKS) : 32'd0;

    sched_state_e    state, state_nxt;
    logic            tmr_load, tmr_tc, cur_d, blk_last;
    logic [TW-1:0]   tmr_val, cnt_nxt;
    logic [BX_W-1:0] bx_nxt;
    logic [BY_W-1:0] by_nxt;
    logic [31:0]     pf_left, pf_nxt;

    me_phase_timer #(.W(TW)) u_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .count_next (cnt_nxt),
        .tc         (tmr_tc)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        bx_nxt    = block_x;
        by_nxt    = block_y;
        pf_nxt    = pf_left;
        if (abort) begin
            state_nxt = IDLE;
            tmr_load  = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = PRIME;
                        tmr_load  = 1'b1;
                        tmr_val   = PRIME_LAST;
                        bx_nxt    = '0;
                        by_nxt    = '0;
                        pf_nxt    = PF_INIT;
                    end
                end
                PRIME: begin
                    if (tmr_tc) state_nxt = WAIT_REF;
                end
                WAIT_REF: begin
                    if (sram_ready) begin
                        state_nxt = RUN;
                        tmr_load  = 1'b1;
                        tmr_val   = RUN_LAST;
                    end
                end
                RUN: begin
                    if (tmr_tc) begin
                        if (pf_left != '0) pf_nxt = pf_left - 32'd1;
                        if (block_x == BX_LAST) begin
                            if (block_y == BY_LAST) begin
                                state_nxt = FINISH;
                            end else begin
                                bx_nxt    = '0;
                                by_nxt    = block_y + BY_W'(1);
                                state_nxt = WAIT_REF;
                            end
                        end else begin
                            bx_nxt   = block_x + BX_W'(1);
                            tmr_load = 1'b1;
                            tmr_val  = RUN_LAST;
                        end
                    end
                end
                FINISH:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        // Prefetch window opens at each block start and closes after CUR_LOAD_CYCLES.
        cur_d = 1'b0;
        if (state_nxt == PRIME) begin
            cur_d = 1'b1;
        end else if (state_nxt == RUN) begin
            if (tmr_load) begin
                cur_d = (pf_nxt != '0);
            end else if (cnt_nxt == CUR_OFF) begin
                cur_d = 1'b0;
            end else begin
                cur_d = cur_read_en;
            end
        end
        blk_last = (state_nxt == RUN) && (cnt_nxt == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            block_x        <= '0;
            block_y        <= '0;
            pf_left        <= '0;
            busy           <= 1'b0;
            ad_valid       <= 1'b0;
            ref_next_line  <= 1'b0;
            block_done     <= 1'b0;
            cur_next_block <= 1'b0;
            frame_done     <= 1'b0;
            cur_read_en    <= 1'b0;
        end else begin
            block_x        <= bx_nxt;
            block_y        <= by_nxt;
            pf_left        <= pf_nxt;
            busy           <= (state_nxt != IDLE);
            ad_valid       <= (state_nxt == RUN);
            ref_next_line  <= (state_nxt == WAIT_REF) && (state != WAIT_REF);
            block_done     <= blk_last;
            cur_next_block <= blk_last;
            frame_done     <= (state_nxt == FINISH);
            cur_read_en    <= cur_d;
        end
    end

`ifdef ME_SCHED_PERF_EN
    logic start_acc;
    assign start_acc = (state == IDLE) && start && !abort;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (start_acc) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy && (perf_cycles != 32'hFFFF_FFFF)) perf_cycles <= perf_cycles + 32'd1;
            if ((state == WAIT_REF) && (perf_stalls != 32'hFFFF_FFFF)) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`else
    assign perf_cycles = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_me_block_scheduler.sv
// tb_me_block_scheduler: randomized frame runs against a schedule-level reference model.
module tb_me_block_scheduler;
    localparam int BPL       = 3;
    localparam int LPF       = 2;
    localparam int CPB       = 23;
    localparam int CLC       = 16;
    localparam int PB        = 2;
    localparam int BXW       = 9;
    localparam int BYW       = 9;
    localparam int PRIME_LEN = PB * CLC;
`ifdef ME_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic           clk, rst_n, start, abort, sram_ready;
    logic           ref_next_line, cur_read_en, cur_next_block, ad_valid, block_done;
    logic [BXW-1:0] block_x;
    logic [BYW-1:0] block_y;
    logic           busy, frame_done;
    logic [31:0]    perf_cycles, perf_stalls;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit cur, rnl, adv, bd, busy, fd, wr, srdy, st;
        int bx, by;
    } exp_t;
    exp_t q[$];

    me_block_scheduler #(
        .BLOCKS_PER_LINE (BPL), .LINES_PER_FRAME (LPF), .CYCLES_PER_BLOCK(CPB),
        .CUR_LOAD_CYCLES (CLC), .PRIME_BLOCKS    (PB),  .BX_W(BXW), .BY_W(BYW)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start(start), .abort(abort), .sram_ready(sram_ready),
        .ref_next_line(ref_next_line), .cur_read_en(cur_read_en), .cur_next_block(cur_next_block),
        .ad_valid(ad_valid), .block_done(block_done), .block_x(block_x), .block_y(block_y),
        .busy(busy), .frame_done(frame_done), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t blank(input int bx, input int by);
        exp_t e;
        e = '{default: 0};
        e.bx = bx;
        e.by = by;
        return e;
    endfunction

    // Expected cycle-by-cycle schedule of one frame: prime, then per row a reference
    // wait of (delay+1) cycles followed by BPL blocks of CPB cycles, then finish.
    task automatic build_frame(input int d0, input int d1, input bit noise);
        exp_t e;
        q.delete();
        for (int i = 0; i < PRIME_LEN; i++) begin
            e = blank(0, 0);
            e.cur = 1; e.busy = 1;
            e.srdy = noise && ($urandom_range(0, 3) == 0);
            e.st   = noise && ($urandom_range(0, 7) == 0);
            q.push_back(e);
        end
        for (int r = 0; r < LPF; r++) begin
            int d;
            d = (r == 0) ? d0 : d1;
            for (int i = 0; i <= d; i++) begin
                e = blank(0, r);
                e.busy = 1; e.wr = 1; e.rnl = (i == 0); e.srdy = (i == d);
                e.st = noise && ($urandom_range(0, 7) == 0);
                q.push_back(e);
            end
            for (int b = 0; b < BPL; b++) begin
                for (int p = 0; p < CPB; p++) begin
                    e = blank(b, r);
                    e.busy = 1; e.adv = 1; e.bd = (p == CPB - 1);
                    e.cur  = ((r * BPL + b + PB) < (BPL * LPF)) && (p < CLC);
                    e.srdy = noise && ($urandom_range(0, 3) == 0);
                    e.st   = noise && (($urandom_range(0, 7) == 0) || (r == 0 && b == 0 && p == 5));
                    q.push_back(e);
                end
            end
        end
        e = blank(BPL - 1, LPF - 1);
        e.busy = 1; e.fd = 1;
        q.push_back(e);
        e = blank(BPL - 1, LPF - 1);
        e.srdy = noise && ($urandom_range(0, 1) == 0);
        q.push_back(e);
    endtask

    task automatic run_frame(input string tag, input int d0, input int d1, input bit noise, input int abort_at);
        int pc, ps;
        logic [6:0] act, expv;
        build_frame(d0, d1, noise);
        @(negedge clk);
        start = 1; sram_ready = 0; abort = 0;
        pc = 0; ps = 0;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            act  = {cur_read_en, ref_next_line, ad_valid, block_done, cur_next_block, busy, frame_done};
            expv = {q[i].cur, q[i].rnl, q[i].adv, q[i].bd, q[i].bd, q[i].busy, q[i].fd};
            n_checks++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL %s ctrl cyc=%0d got=%b want=%b (cur,rnl,adv,bd,cnb,busy,fd)", tag, i, act, expv);
            end
            n_checks++;
            if (block_x !== BXW'(q[i].bx) || block_y !== BYW'(q[i].by)) begin
                n_fail++;
                $display("FAIL %s pos cyc=%0d got=(%0d,%0d) want=(%0d,%0d)", tag, i, block_x, block_y, q[i].bx, q[i].by);
            end
            n_checks++;
            if (perf_cycles !== (PERF ? 32'(pc) : 32'd0) || perf_stalls !== (PERF ? 32'(ps) : 32'd0)) begin
                n_fail++;
                $display("FAIL %s perf cyc=%0d got=%0d/%0d want=%0d/%0d", tag, i, perf_cycles, perf_stalls,
                         PERF ? pc : 0, PERF ? ps : 0);
            end
            pc += int'(q[i].busy);
            ps += int'(q[i].wr);
            start = q[i].st; sram_ready = q[i].srdy; abort = (i == abort_at);
            if (i == abort_at) begin
                @(negedge clk);
                start = 0; sram_ready = 0; abort = 0;
                act = {cur_read_en, ref_next_line, ad_valid, block_done, cur_next_block, busy, frame_done};
                n_checks++;
                if (act !== 7'b0) begin
                    n_fail++;
                    $display("FAIL %s abort_ctrl got=%b want=0000000", tag, act);
                end
                n_checks++;
                if (block_x !== BXW'(q[i].bx) || block_y !== BYW'(q[i].by)) begin
                    n_fail++;
                    $display("FAIL %s abort_pos got=(%0d,%0d) want=(%0d,%0d)", tag, block_x, block_y, q[i].bx, q[i].by);
                end
                break;
            end
        end
        start = 0; sram_ready = 0; abort = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; abort = 0; sram_ready = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ref_next_line, cur_read_en, cur_next_block, ad_valid, block_done, busy, frame_done} !== 7'b0 ||
            block_x !== '0 || block_y !== '0 || perf_cycles !== '0 || perf_stalls !== '0) begin
            n_fail++;
            $display("FAIL reset_values busy=%b cur=%b bx=%0d by=%0d want all 0", busy, cur_read_en, block_x, block_y);
        end
        rst_n = 1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ad_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle busy=%b ad_valid=%b want 0 0", busy, ad_valid);
        end
    endtask

    task automatic test_cold_boot_gating();
        run_frame("cold_boot", 10, $urandom_range(0, 6), 1'b1, -1);
    endtask

    task automatic test_full_frame();
        run_frame("frame_coincident", 0, 0, 1'b1, -1);
        for (int k = 0; k < 3; k++) begin
            run_frame("frame_rand", $urandom_range(0, 8), $urandom_range(0, 8), 1'b1, -1);
        end
    endtask

    task automatic test_abort();
        // block (1,0) phase 7 with prompt sram_ready: 32 prime + 1 wait + 23 + 7
        run_frame("abort_run", 0, 0, 1'b0, PRIME_LEN + 1 + CPB + 7);
        @(negedge clk);
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || cur_read_en !== 1'b0 || block_x !== BXW'(1)) begin
            n_fail++;
            $display("FAIL abort_start_idle busy=%b cur=%b bx=%0d want 0 0 1", busy, cur_read_en, block_x);
        end
        run_frame("abort_restart", $urandom_range(0, 4), $urandom_range(0, 4), 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_a", $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, -1);
        run_frame("b2b_b", $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, -1);
    endtask

    task automatic test_reset_mid_prime();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (cur_read_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL prime_active cur=%b busy=%b want 1 1", cur_read_en, busy);
        end
        #2 rst_n = 0;
        #1;
        n_checks++;
        if ({ref_next_line, cur_read_en, cur_next_block, ad_valid, block_done, busy, frame_done} !== 7'b0 ||
            block_x !== '0 || block_y !== '0 || perf_cycles !== '0 || perf_stalls !== '0) begin
            n_fail++;
            $display("FAIL async_reset cur=%b busy=%b perf=%0d want all 0", cur_read_en, busy, perf_cycles);
        end
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || cur_read_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release busy=%b cur=%b want 0 0", busy, cur_read_en);
        end
    endtask

    initial begin
        test_reset();
        test_cold_boot_gating();
        test_full_frame();
        test_abort();
        test_back_to_back();
        test_reset_mid_prime();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
